sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that splits instruction/data accesses into 16-bit SRAM sub-transactions.
module sram_arbiter #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_dtw,
  input  logic [15:0] mem_dtr,
  input  logic        mem_done,
  output logic        busy
);
  localparam logic [2:0] S_SETTLE = 3'd0, S_IDLE = 3'd1, S_CHECK = 3'd2,
                         S_ISSUE = 3'd3, S_WAIT = 3'd4, S_RESP = 3'd5;
  localparam int unsigned SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [2:0] state;
  logic [SW-1:0] scnt;
  logic last_i, port_d, rw, err;
  logic [1:0] size, cnt, cnt_max;
  logic [31:0] addr, wdata, rd_val;
  logic [15:0] lo;
  logic [7:0] wbyte;
  logic pick_d, mis, settled, last_sub, act;
  always_comb begin
    pick_d = d_valid && (!i_valid || last_i);
    mis = size == 2'b11 || (size == 2'b10 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
    cnt_max = rw ? (size == 2'b00 ? 2'd0 : size == 2'b01 ? 2'd1 : 2'd3)
                 : (size == 2'b10 ? 2'd1 : 2'd0);
    last_sub = cnt == cnt_max;
    settled = SETTLE < 2 || scnt == SW'(SETTLE - 1);
    wbyte = wdata[{cnt, 3'b000} +: 8];
    rd_val = size == 2'b00 ? {24'd0, addr[0] ? mem_dtr[15:8] : mem_dtr[7:0]}
           : size == 2'b01 ? {16'd0, mem_dtr} : {mem_dtr, lo};
    act = state == S_ISSUE || state == S_WAIT;
  end
  assign busy = state != S_IDLE;
  assign mem_valid = state == S_ISSUE;
  assign mem_rw = act && rw;
  // reads address the halfword holding the target; writes walk bytes upward
  assign mem_addr = !act ? 32'd0 : rw ? addr + {30'd0, cnt} : {addr[31:2], addr[1] | cnt[0], 1'b0};
  assign mem_dtw = act && rw ? {wbyte, wbyte} : 16'd0;
  assign i_ready = state == S_RESP && !port_d;
  assign d_ready = state == S_RESP && port_d;
  assign i_err = i_ready && err;
  assign d_err = d_ready && err;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_SETTLE;
      scnt <= '0;
      last_i <= 1'b1;
      port_d <= 1'b0;
      rw <= 1'b0;
      err <= 1'b0;
      size <= 2'b00;
      cnt <= 2'd0;
      addr <= 32'd0;
      wdata <= 32'd0;
      lo <= 16'd0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
    end else begin
      case (state)
        S_SETTLE: begin
          scnt <= scnt + 1'b1;
          if (settled) state <= S_IDLE;
        end
        S_IDLE: if (i_valid || d_valid) begin
          port_d <= pick_d;
          last_i <= !pick_d;
          rw <= pick_d && d_rw;
          size <= pick_d ? d_size : 2'b10;
          addr <= pick_d ? d_addr : i_addr;
          wdata <= d_wdata;
          err <= 1'b0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          err <= mis;
          cnt <= 2'd0;
          state <= mis ? S_RESP : S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (mem_done) begin
          cnt <= cnt + 1'b1;
          if (!rw && !last_sub) lo <= mem_dtr;
          if (!rw && last_sub && port_d) d_rdata <= rd_val;
          if (!rw && last_sub && !port_d) i_rdata <= rd_val;
          state <= last_sub ? S_RESP : S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
